// File: rtl/i2s_pkg.sv
// Shared I2S frame geometry: 64 bclk slots per frame, left word captured in slots 1..32.
package i2s_pkg;

  localparam int SLOT_BITS       = 32;
  localparam int FRAME_SLOTS     = 64;
  localparam int LEFT_FIRST_SLOT = 1;
  localparam int LEFT_LAST_SLOT  = 32;

  typedef logic [5:0] slot_t;

  // Left bit j lands in slot j+1: the one-bclk I2S delay after the ws fall.
  function automatic logic is_left_capture(input slot_t s);
    return (s >= slot_t'(LEFT_FIRST_SLOT)) && (s <= slot_t'(LEFT_LAST_SLOT));
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider and 64-slot frame counter; rise_stb is combinational, one clk wide.
// No backpressure: the bus free-runs while en is high and parks at zero otherwise.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int HALF_DIV = 8
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  output logic  bclk,
  output logic  ws,
  output logic  rise_stb,
  output slot_t slot
);

  localparam int            CW = $clog2(HALF_DIV);
  localparam logic [CW-1:0] TC = CW'(HALF_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          tc;
  logic          fall_stb;
  slot_t         slot_nx;

  assign tc       = reset && en && (div_cnt == TC);
  assign rise_stb = tc && !bclk;
  assign fall_stb = tc && bclk;
  assign slot_nx  = slot + 6'd1;

  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      ws      <= 1'b0;
      slot    <= '0;
    end else begin
      if (tc) begin
        div_cnt <= '0;
        bclk    <= !bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      // ws follows the slot number so it changes on the same bclk fall.
      if (fall_stb) begin
        slot <= slot_nx;
        ws   <= (slot_nx >= slot_t'(SLOT_BITS));
      end
    end
  end

endmodule

// File: rtl/i2s_left_rx.sv
// I2S master receiver: left word sign-extended to 32 bits, pulsed one clk after the slot-32 rise.
// No backpressure: sample_valid is a single-cycle pulse and sample_out holds until the next one.
module i2s_left_rx
  import i2s_pkg::*;
#(
  parameter int HALF_DIV  = 8,
  parameter int DATA_BITS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        i2s_sd,
  output logic        i2s_bclk,
  output logic        i2s_ws,
  output logic [31:0] sample_out,
  output logic        sample_valid
);

  logic        rise_stb;
  slot_t       slot;
  logic        sd_q;
  logic [31:0] sh;
  logic [31:0] sh_nx;
  logic [31:0] word_ext;
  logic        capture;
  logic        last_stb;
  logic        unused_bits;

  i2s_clkgen #(
    .HALF_DIV (HALF_DIV)
  ) u_clkgen (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .bclk     (i2s_bclk),
    .ws       (i2s_ws),
    .rise_stb (rise_stb),
    .slot     (slot)
  );

  assign capture  = rise_stb && is_left_capture(slot);
  assign last_stb = rise_stb && (slot == slot_t'(LEFT_LAST_SLOT));
  assign sh_nx    = {sh[30:0], sd_q};

  // The output is built from the post-shift value so the last bit is included.
  if (DATA_BITS == 32) begin : g_full
    assign word_ext = sh_nx;
  end else begin : g_ext
    assign word_ext = {{(32 - DATA_BITS){sh_nx[31]}}, sh_nx[31 -: DATA_BITS]};
  end

  assign unused_bits = ^{sh[31], sh_nx};

  always_ff @(posedge clk) begin
    if (!reset) begin
      sd_q         <= 1'b0;
      sh           <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else if (!en) begin
      sd_q         <= i2s_sd;
      sh           <= '0;
      sample_valid <= 1'b0;
    end else begin
      sd_q         <= i2s_sd;
      sample_valid <= last_stb;
      if (capture) begin
        sh <= sh_nx;
      end
      if (last_stb) begin
        sample_out <= word_ext;
      end
    end
  end

endmodule

// File: tb/tb_i2s_left_rx.sv
// Directed bench: two receivers (24- and 32-bit words) on one mic model, HALF_DIV=2.
module tb_i2s_left_rx;

  localparam int HD = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        en    = 1'b0;
  logic        sd    = 1'b0;
  logic        bclk24, ws24, vld24;
  logic        bclk32, ws32, vld32;
  logic [31:0] out24, out32;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          t0          = 0;
  logic        run_q       = 1'b0;

  // Mic model state: slot words are left-justified 32-bit values.
  logic [31:0] lw        = 32'h0;
  logic [31:0] rw        = 32'h0;
  int          k         = 0;
  logic        ws_prev   = 1'b0;
  logic        bclk_prev = 1'b0;

  logic        pv24 = 1'b0;
  logic        pv32 = 1'b0;
  int          pt24[$];
  int          pt32[$];
  logic [31:0] pw24[$];
  logic [31:0] pw32[$];

  i2s_left_rx #(.HALF_DIV(HD), .DATA_BITS(24)) dut24 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .i2s_sd       (sd),
    .i2s_bclk     (bclk24),
    .i2s_ws       (ws24),
    .sample_out   (out24),
    .sample_valid (vld24)
  );

  i2s_left_rx #(.HALF_DIV(HD), .DATA_BITS(32)) dut32 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .i2s_sd       (sd),
    .i2s_bclk     (bclk32),
    .i2s_ws       (ws32),
    .sample_out   (out32),
    .sample_valid (vld32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    run_q <= en && reset;
  end

  // Mic drives the next bit after every bclk fall; a ws change starts a new half-frame.
  always @(negedge clk) begin
    if (!run_q) begin
      k         = 0;
      ws_prev   = 1'b0;
      bclk_prev = 1'b0;
    end else begin
      if (bclk_prev && !bclk24) begin
        if (ws24 != ws_prev) begin
          k  = 0;
          sd = ws24 ? lw[0] : rw[0];
        end else begin
          k  = k + 1;
          sd = ws24 ? rw[5'(32 - k)] : lw[5'(32 - k)];
        end
        ws_prev = ws24;
      end
      bclk_prev = bclk24;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic [31:0] hold24, input logic [31:0] hold32);
    chk({tag, "_bclk24"}, 32'(bclk24), 32'd0);
    chk({tag, "_ws24"},   32'(ws24),   32'd0);
    chk({tag, "_vld24"},  32'(vld24),  32'd0);
    chk({tag, "_out24"},  out24,       hold24);
    chk({tag, "_bclk32"}, 32'(bclk32), 32'd0);
    chk({tag, "_ws32"},   32'(ws32),   32'd0);
    chk({tag, "_vld32"},  32'(vld32),  32'd0);
    chk({tag, "_out32"},  out32,       hold32);
  endtask

  // Checks bus timing every cycle and records pulses, up to and including cycle n-1 after t0.
  task automatic run_until(input int n);
    int rel;
    forever begin
      @(negedge clk);
      rel = cyc - t0;
      chk("bclk24", 32'(bclk24), 32'((rel / HD) % 2));
      chk("ws24",   32'(ws24),   32'(((rel / (2 * HD)) % 64) >= 32));
      chk("bclk32", 32'(bclk32), 32'((rel / HD) % 2));
      chk("ws32",   32'(ws32),   32'(((rel / (2 * HD)) % 64) >= 32));
      if (vld24) begin
        chk("vld24_single", 32'(pv24), 32'd0);
        pt24.push_back(rel);
        pw24.push_back(out24);
      end
      if (vld32) begin
        chk("vld32_single", 32'(pv32), 32'd0);
        pt32.push_back(rel);
        pw32.push_back(out32);
      end
      pv24 = vld24;
      pv32 = vld32;
      if (rel >= n - 1) break;
    end
  endtask

  task automatic expect_pulse(input string tag, input int t, input logic [31:0] e24, input logic [31:0] e32);
    chk({tag, "_cnt24"}, 32'(pt24.size()), 32'd1);
    chk({tag, "_cnt32"}, 32'(pt32.size()), 32'd1);
    if (pt24.size() > 0) begin
      chk({tag, "_t24"},   32'(pt24[0]), 32'(t));
      chk({tag, "_val24"}, pw24[0],      e24);
    end
    if (pt32.size() > 0) begin
      chk({tag, "_t32"},   32'(pt32[0]), 32'(t));
      chk({tag, "_val32"}, pw32[0],      e32);
    end
    pt24.delete(); pw24.delete(); pt32.delete(); pw32.delete();
  endtask

  task automatic expect_none(input string tag);
    chk({tag, "_cnt24"}, 32'(pt24.size()), 32'd0);
    chk({tag, "_cnt32"}, 32'(pt32.size()), 32'd0);
    pt24.delete(); pw24.delete(); pt32.delete(); pw32.delete();
  endtask

  initial begin
    // Reset asserted together with en: reset must win.
    reset = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("rst", 32'h0, 32'h0);

    @(posedge clk); #1;
    reset = 1'b1;
    en    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_quiet("idle0", 32'h0, 32'h0);
    end

    // Negative 24-bit word; low slot byte must be ignored by the 24-bit receiver.
    lw = 32'hA5A5A57E;
    rw = 32'h12345600;
    @(posedge clk); #1;
    en = 1'b1;
    t0 = cyc;
    run_until(131);
    expect_pulse("t1_neg", 130, 32'hFFA5A5A5, 32'hA5A5A57E);

    // Positive word; the right slot carries a distinctive value that must never surface.
    lw = 32'h12345600;
    rw = 32'hA5A5A57E;
    run_until(400);
    expect_pulse("t2_pos", 386, 32'h00123456, 32'h12345600);

    // Drop en mid-left slot of the third frame, hold idle 20 cycles, re-enable.
    run_until(612);
    expect_none("t4_pre");
    @(posedge clk); #1;
    en = 1'b0;
    lw = 32'h7FFFFF00;
    @(negedge clk);
    repeat (19) begin
      @(negedge clk);
      chk_quiet("t4_idle", 32'h00123456, 32'h12345600);
    end
    pv24 = 1'b0;
    pv32 = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    t0 = cyc;
    run_until(131);
    expect_pulse("t4_reen", 130, 32'h007FFFFF, 32'h7FFFFF00);

    // One-cycle reset mid-left slot: outputs clear, then a clean restart.
    run_until(316);
    expect_none("t5_pre");
    @(posedge clk); #1;
    reset = 1'b0;
    lw    = 32'hC0FFEE12;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    t0    = cyc;
    @(negedge clk);
    chk_quiet("t5_rst", 32'h0, 32'h0);
    run_until(131);
    expect_pulse("t5_restart", 130, 32'hFFC0FFEE, 32'hC0FFEE12);

    // Full-width word with MSB and LSB set.
    lw = 32'h80000001;
    rw = 32'h7F00FF00;
    run_until(400);
    expect_pulse("t6_full", 386, 32'hFF800000, 32'h80000001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
